// File: rtl/store_buffer.sv
// store_buffer
//   Write-back store buffer between a pipeline memory stage and a single-port
//   backing memory. Stores are queued in a circular FIFO of DEPTH {addr, data}
//   entries and drained to memory one at a time. Loads that hit a queued store
//   (64-bit word granularity) are forwarded the same cycle from the youngest
//   matching entry. Loads that miss stall the memory stage and are sent to
//   memory ahead of any further queued stores.
//
// Handshakes
//   Backing memory: mem_req is held high with mem_addr/mem_wdata/mem_we stable
//   (all registered) until a one-cycle mem_ack. mem_rdata is valid only with
//   mem_ack. mem_ack while no request is outstanding is ignored.
//   Memory stage: while stall_mem=1 the stage holds DM_* inputs unchanged.
//   A store is accepted on the edge of the first cycle it sees stall_mem=0.
//   A load completes in the cycle it sees stall_mem=0, with the result on
//   DM_readData in that same cycle.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   DM_addr, DM_writeData  memory-stage byte address and store data
//   DM_writeEnable         store request (wins over a simultaneous load)
//   DM_readEnable          load request
//   DM_readData            load result, 0 when no load completes
//   stall_mem              memory stage must hold its inputs
//   sb_empty               no pending stores
//   mem_req/mem_we         backing-memory request, 1 = write
//   mem_addr/mem_wdata     backing-memory address and write data
//   mem_ack/mem_rdata      completion pulse and read data
//   The FSM state is held in the named signal 'state' (IDLE/ST_BUSY/LD_BUSY).
module store_buffer #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  output logic [N-1:0] DM_readData,
  output logic         stall_mem,
  output logic         sb_empty,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ST_BUSY, LD_BUSY} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  ent_addr [DEPTH];
  logic [N-1:0]  ent_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          store_req, load_req, full;
  logic          hit, load_miss, ld_done, push, pop;
  logic [N-1:0]  fwd_data;
  logic [N-1:0]  maddr_nxt, mwdata_nxt;
  logic          mwe_nxt;

  // Byte-offset bits do not take part in word matching.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^DM_addr[2:0];

  assign store_req = DM_writeEnable;
  assign load_req  = DM_readEnable && !DM_writeEnable;
  assign full      = (count == CW'(DEPTH));
  assign sb_empty  = (count == '0);

  // Youngest match wins: scan oldest to newest, later matches overwrite.
  // Uses pre-edge contents, so the head stays matchable in its pop cycle.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) &&
          (ent_addr[head + PW'(k)][N-1:3] == DM_addr[N-1:3])) begin
        hit      = 1'b1;
        fwd_data = ent_data[head + PW'(k)];
      end
    end
  end

  assign load_miss = load_req && !hit;
  assign ld_done   = (state == LD_BUSY) && mem_ack;
  assign pop       = (state == ST_BUSY) && mem_ack && !reset;
  // Full is judged on pre-edge count: a pop in the same cycle does not help.
  assign push      = store_req && !full && !reset;

  assign mem_req   = (state != IDLE) && !reset;

  always_comb begin
    DM_readData = '0;
    stall_mem   = 1'b0;
    if (!reset) begin
      if (store_req) begin
        stall_mem = full;
      end else if (load_req && hit) begin
        DM_readData = fwd_data;
      end else if (load_miss) begin
        stall_mem = !ld_done;
        if (ld_done) DM_readData = mem_rdata;
      end
    end
  end

  // Next state and the request registers loaded on leaving IDLE.
  always_comb begin
    state_nxt  = state;
    maddr_nxt  = mem_addr;
    mwdata_nxt = mem_wdata;
    mwe_nxt    = mem_we;
    case (state)
      IDLE: begin
        if (load_miss) begin
          state_nxt = LD_BUSY;
          maddr_nxt = DM_addr;
          mwe_nxt   = 1'b0;
        end else if (!sb_empty) begin
          state_nxt  = ST_BUSY;
          maddr_nxt  = ent_addr[head];
          mwdata_nxt = ent_data[head];
          mwe_nxt    = 1'b1;
        end
      end
      ST_BUSY: if (mem_ack) state_nxt = IDLE;
      LD_BUSY: if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_addr  <= maddr_nxt;
      mem_wdata <= mwdata_nxt;
      mem_we    <= mwe_nxt;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: validity comes from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= DM_addr;
      ent_data[tail] <= DM_writeData;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] DM_addr, DM_writeData, DM_readData;
  logic        DM_writeEnable, DM_readEnable;
  logic        stall_mem, sb_empty;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  store_buffer #(.N(64), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .DM_addr(DM_addr), .DM_writeData(DM_writeData),
    .DM_writeEnable(DM_writeEnable), .DM_readEnable(DM_readEnable),
    .DM_readData(DM_readData), .stall_mem(stall_mem), .sb_empty(sb_empty),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rst, we, re, ack;
    logic [63:0] addr, wdata, rdata;
    logic [63:0] e_rd;
    logic        e_stall, e_empty, e_req, e_mwe;
    logic [63:0] e_maddr;
  } vec_t;

  vec_t vt[$];
  logic [63:0] exp_q[$];   // pending stores: addr, data pairs in drain order

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs on the falling edge; outputs checked 1 time unit later.
  task automatic drive(input logic we, input logic re, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic ack, input logic [63:0] rdata);
    @(negedge clk);
    reset = 1'b0; DM_writeEnable = we; DM_readEnable = re; DM_addr = addr;
    DM_writeData = wdata; mem_ack = ack; mem_rdata = rdata;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; DM_writeEnable = 0; DM_readEnable = 0; DM_addr = 0;
    DM_writeData = 0; mem_ack = 0; mem_rdata = 0;
    @(negedge clk);
    #1;
  endtask

  task automatic add_vec(input logic we, input logic re, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic ack, input logic [63:0] rdata,
                         input logic [63:0] e_rd, input logic e_stall, input logic e_empty,
                         input logic e_req, input logic e_mwe, input logic [63:0] e_maddr);
    vec_t v;
    v.rst = 0; v.we = we; v.re = re; v.ack = ack; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.e_rd = e_rd; v.e_stall = e_stall; v.e_empty = e_empty;
    v.e_req = e_req; v.e_mwe = e_mwe; v.e_maddr = e_maddr;
    vt.push_back(v);
  endtask

  // Drain queued stores from exp_q, checking each write request, then emptiness.
  task automatic drain(input string tag);
    logic [63:0] ea, ed;
    bit got;
    while (exp_q.size() >= 2) begin
      ea = exp_q.pop_front();
      ed = exp_q.pop_front();
      got = 0;
      for (int w = 0; w < 10 && !got; w++) begin
        drive(0, 0, 0, 0, 0, 0);
        if (mem_req) got = 1;
      end
      chk({tag, "_wr_req"}, {63'd0, got}, 64'd1);
      if (!got) return;
      chk({tag, "_wr_we"},    {63'd0, mem_we}, 64'd1);
      chk({tag, "_wr_addr"},  mem_addr, ea);
      chk({tag, "_wr_data"},  mem_wdata, ed);
      drive(0, 0, 0, 0, 1, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk({tag, "_empty"}, {63'd0, sb_empty}, 64'd1);
    chk({tag, "_idle"},  {63'd0, mem_req},  64'd0);
  endtask

  initial begin
    reset = 1; DM_writeEnable = 0; DM_readEnable = 0; DM_addr = 0;
    DM_writeData = 0; mem_ack = 0; mem_rdata = 0;

    // ---------------- reset state ----------------
    chk("rst_stall", {63'd0, stall_mem}, 64'd0);
    chk("rst_req",   {63'd0, mem_req},   64'd0);
    chk("rst_rd",    DM_readData,        64'd0);
    do_reset();
    chk("rst_empty", {63'd0, sb_empty}, 64'd1);
    chk("rst_mwe",   {63'd0, mem_we},   64'd0);
    chk("rst_maddr", mem_addr,          64'd0);
    chk("rst_wdata", mem_wdata,         64'd0);

    // ------------- table: forwarding, youngest match, miss latency -------------
    //       we re addr    wdata ack rdata   e_rd  stl emp req mwe maddr
    add_vec(1, 0, 'h10, 'hAA, 0, 0,     0,    0,  1,  0,  0,  'h0);  // store 0x10
    add_vec(0, 1, 'h10, 0,    0, 0,     'hAA, 0,  0,  0,  0,  'h0);  // fwd hit
    add_vec(0, 0, 0,    0,    0, 0,     0,    0,  0,  1,  1,  'h10); // write out
    add_vec(0, 0, 0,    0,    1, 0,     0,    0,  0,  1,  1,  'h10); // ack, pop
    add_vec(0, 0, 0,    0,    0, 0,     0,    0,  1,  0,  1,  'h10);
    add_vec(1, 0, 'h20, 1,    0, 0,     0,    0,  1,  0,  1,  'h10); // 0x20<-1
    add_vec(1, 0, 'h20, 2,    0, 0,     0,    0,  0,  0,  1,  'h10); // 0x20<-2
    add_vec(0, 1, 'h24, 0,    0, 0,     2,    0,  0,  1,  1,  'h20); // youngest
    add_vec(0, 1, 'h24, 0,    1, 0,     2,    0,  0,  1,  1,  'h20); // hit during pop
    add_vec(0, 0, 0,    0,    0, 0,     0,    0,  0,  0,  1,  'h20);
    add_vec(0, 0, 0,    0,    1, 0,     0,    0,  0,  1,  1,  'h20);
    add_vec(0, 0, 0,    0,    0, 0,     0,    0,  1,  0,  1,  'h20);
    add_vec(0, 1, 'h40, 0,    0, 0,     0,    1,  1,  0,  1,  'h20); // miss
    add_vec(0, 1, 'h40, 0,    0, 0,     0,    1,  1,  1,  0,  'h40);
    add_vec(0, 1, 'h40, 0,    0, 0,     0,    1,  1,  1,  0,  'h40);
    add_vec(0, 1, 'h40, 0,    0, 0,     0,    1,  1,  1,  0,  'h40);
    add_vec(0, 1, 'h40, 0,    1, 'h55,  'h55, 0,  1,  1,  0,  'h40); // ack
    add_vec(0, 0, 0,    0,    0, 0,     0,    0,  1,  0,  0,  'h40);
    add_vec(0, 0, 0,    0,    1, 'h77,  0,    0,  1,  0,  0,  'h40); // stray ack
    add_vec(0, 1, 'h48, 0,    0, 0,     0,    1,  1,  0,  0,  'h40); // min latency
    add_vec(0, 1, 'h48, 0,    1, 'h99,  'h99, 0,  1,  1,  0,  'h48);
    add_vec(0, 0, 0,    0,    0, 0,     0,    0,  1,  0,  0,  'h48);

    foreach (vt[i]) begin
      drive(vt[i].we, vt[i].re, vt[i].addr, vt[i].wdata, vt[i].ack, vt[i].rdata);
      chk($sformatf("v%0d_rd", i),    DM_readData,        vt[i].e_rd);
      chk($sformatf("v%0d_stall", i), {63'd0, stall_mem}, {63'd0, vt[i].e_stall});
      chk($sformatf("v%0d_empty", i), {63'd0, sb_empty},  {63'd0, vt[i].e_empty});
      chk($sformatf("v%0d_req", i),   {63'd0, mem_req},   {63'd0, vt[i].e_req});
      chk($sformatf("v%0d_mwe", i),   {63'd0, mem_we},    {63'd0, vt[i].e_mwe});
      chk($sformatf("v%0d_maddr", i), mem_addr,           vt[i].e_maddr);
    end

    // ------------- full buffer: 5th store stalls until first write ack -------------
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 64'h100 + 64'(8 * k), 64'(k + 1), 0, 0);
      chk($sformatf("full_st%0d_stall", k), {63'd0, stall_mem}, 64'd0);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 64'h120, 64'd5, 0, 0);
      chk($sformatf("full_st4_stall%0d", k), {63'd0, stall_mem}, 64'd1);
      chk($sformatf("full_st4_req%0d", k),   {63'd0, mem_req},   64'd1);
    end
    chk("full_head_addr", mem_addr, 64'h100);
    drive(1, 0, 64'h120, 64'd5, 1, 0);          // pop this edge, still no enqueue
    chk("full_pop_stall", {63'd0, stall_mem}, 64'd1);
    drive(1, 0, 64'h120, 64'd5, 0, 0);          // now count=3, enqueues
    chk("full_accept_stall", {63'd0, stall_mem}, 64'd0);
    drive(1, 0, 64'h128, 64'd6, 0, 0);          // count back at 4: must stall again
    chk("full_again_stall", {63'd0, stall_mem}, 64'd1);
    exp_q = '{64'h108, 64'd2, 64'h110, 64'd3, 64'h118, 64'd4, 64'h120, 64'd5};
    drain("full");

    // ------------- load miss waits for in-flight store, then beats stores -------------
    do_reset();
    drive(1, 0, 64'h200, 64'h11, 0, 0);
    drive(1, 0, 64'h208, 64'h22, 0, 0);
    drive(0, 1, 64'h300, 0, 0, 0);
    chk("arb_st_busy_stall", {63'd0, stall_mem}, 64'd1);
    chk("arb_st_busy_addr",  mem_addr, 64'h200);
    drive(0, 1, 64'h300, 0, 1, 64'hEE);        // write ack, load not done
    chk("arb_wack_stall", {63'd0, stall_mem}, 64'd1);
    chk("arb_wack_rd",    DM_readData, 64'd0);
    drive(0, 1, 64'h300, 0, 0, 0);
    chk("arb_idle_stall", {63'd0, stall_mem}, 64'd1);
    chk("arb_idle_req",   {63'd0, mem_req}, 64'd0);
    drive(0, 1, 64'h300, 0, 1, 64'h33);
    chk("arb_rd_req",   {63'd0, mem_req}, 64'd1);
    chk("arb_rd_we",    {63'd0, mem_we}, 64'd0);
    chk("arb_rd_addr",  mem_addr, 64'h300);
    chk("arb_rd_data",  DM_readData, 64'h33);
    chk("arb_rd_stall", {63'd0, stall_mem}, 64'd0);
    chk("arb_pending",  {63'd0, sb_empty}, 64'd0);
    exp_q = '{64'h208, 64'h22};
    drain("arb");

    // ------------- reset during LD_BUSY discards everything -------------
    do_reset();
    drive(1, 0, 64'h600, 64'h66, 0, 0);
    drive(0, 1, 64'h500, 0, 0, 0);
    chk("rld_miss_stall", {63'd0, stall_mem}, 64'd1);
    drive(0, 1, 64'h500, 0, 0, 0);
    chk("rld_busy_req", {63'd0, mem_req}, 64'd1);
    chk("rld_busy_we",  {63'd0, mem_we}, 64'd0);
    @(negedge clk);
    reset = 1'b1; mem_ack = 1'b0;
    #1;
    chk("rld_in_rst_req",   {63'd0, mem_req}, 64'd0);
    chk("rld_in_rst_stall", {63'd0, stall_mem}, 64'd0);
    chk("rld_in_rst_rd",    DM_readData, 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rld_after_req",   {63'd0, mem_req}, 64'd0);
    chk("rld_after_empty", {63'd0, sb_empty}, 64'd1);
    drive(0, 0, 0, 0, 1, 64'hAB);               // late ack
    chk("rld_late_rd",  DM_readData, 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rld_late_req",   {63'd0, mem_req}, 64'd0);
    chk("rld_late_empty", {63'd0, sb_empty}, 64'd1);
    chk("rld_late_maddr", mem_addr, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
